// File: rtl/sprite_anim_pkg.sv
// Shared types, default geometry/timing constants and address helpers for the
// sprite animation controller (mirroring is enabled by defining SPRITE_MIRROR_EN).
package sprite_anim_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_JUMP = 2'd1,
        S_LAND = 2'd2
    } anim_state_t;

    localparam int unsigned DEF_SPRITE_W    = 64;
    localparam int unsigned DEF_SPRITE_H    = 64;
    localparam int unsigned DEF_NUM_FRAMES  = 4;
    localparam int unsigned DEF_FRAME_TICKS = 6;
    localparam int unsigned DEF_LAND_TICKS  = 8;
    localparam int unsigned DEF_ADDR_W      = 14;

    // Frames are stored back-to-back, so a frame's base is its index shifted
    // past the per-frame pixel bits.
    function automatic logic [31:0] frame_base_addr(input logic [31:0] fidx,
                                                    input int unsigned pix_shift);
        frame_base_addr = fidx << pix_shift;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Box test, optional horizontal mirroring (SPRITE_MIRROR_EN) and ROM address
// composition, registered with one cycle of latency.
module sprite_addr_gen
    import sprite_anim_pkg::*;
#(
    parameter int unsigned SPRITE_W   = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H   = DEF_SPRITE_H,
    parameter int unsigned NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned FI_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              facing_left,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [FI_W-1:0]   frame_idx,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on
);

    localparam int unsigned LX_W = $clog2(SPRITE_W);
    localparam int unsigned LY_W = $clog2(SPRITE_H);

    logic [10:0]       right_s;
    logic [10:0]       bottom_s;
    logic              in_box_s;
    logic [LX_W-1:0]   lx_s;
    logic [LX_W-1:0]   lx_m_s;
    logic [LY_W-1:0]   ly_s;
    logic [31:0]       addr_full_s;
    logic [ADDR_W-1:0] rom_address_q;
    logic              sprite_on_q;

    // 11-bit edges let a sprite hanging off the right/bottom clip rather than wrap
    assign right_s  = {1'b0, pos_x} + 11'(SPRITE_W);
    assign bottom_s = {1'b0, pos_y} + 11'(SPRITE_H);
    assign in_box_s = ({1'b0, DrawX} >= {1'b0, pos_x}) && ({1'b0, DrawX} < right_s) &&
                      ({1'b0, DrawY} >= {1'b0, pos_y}) && ({1'b0, DrawY} < bottom_s);

    assign lx_s = LX_W'(DrawX - pos_x);
    assign ly_s = LY_W'(DrawY - pos_y);

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;

    // Sample the facing direction only at frame boundaries so a frame never flips mid-scan.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            mirror_q <= 1'b0;
        end else if (frame_tick) begin
            mirror_q <= facing_left;
        end else begin
            mirror_q <= mirror_q;
        end
    end

    assign lx_m_s = mirror_q ? (LX_W'(SPRITE_W - 1) - lx_s) : lx_s;
`else
    logic unused_mirror_s;
    assign unused_mirror_s = facing_left ^ frame_tick;
    assign lx_m_s          = lx_s;
`endif

    // Compose {frame, ly, lx}; outside the box only the frame base remains.
    always_comb begin
        addr_full_s = frame_base_addr(32'(frame_idx), LX_W + LY_W);
        if (in_box_s) begin
            addr_full_s = addr_full_s | 32'({ly_s, lx_m_s});
        end else begin
            addr_full_s = addr_full_s;
        end
    end

    // Output register feeding the ROM (which samples on the falling edge).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address_q <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            rom_address_q <= addr_full_s[ADDR_W-1:0];
            sprite_on_q   <= in_box_s;
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_on   = sprite_on_q;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Jump animation sequencer plus sprite ROM address generator; define
// SPRITE_MIRROR_EN to honour facing_left.
module sprite_anim_ctrl
    import sprite_anim_pkg::*;
#(
    parameter int unsigned SPRITE_W    = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H    = DEF_SPRITE_H,
    parameter int unsigned NUM_FRAMES  = DEF_NUM_FRAMES,
    parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int unsigned LAND_TICKS  = DEF_LAND_TICKS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned FI_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              jump_req,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              facing_left,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on,
    output logic [FI_W-1:0]   frame_idx,
    output logic              busy
);

    localparam int unsigned MAX_TICKS = (FRAME_TICKS > LAND_TICKS) ? FRAME_TICKS : LAND_TICKS;
    localparam int unsigned TC_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    anim_state_t     state_q;
    logic [FI_W-1:0] frame_idx_q;
    logic [TC_W-1:0] tick_cnt_q;
    logic            busy_q;

    // Animation FSM; every change is gated by frame_tick so displayed frames never tear.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            frame_idx_q <= '0;
            tick_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    tick_cnt_q <= '0;
                    if (jump_req) begin
                        state_q     <= S_JUMP;
                        frame_idx_q <= FI_W'(1);
                        busy_q      <= 1'b1;
                    end else begin
                        frame_idx_q <= '0;
                        busy_q      <= 1'b0;
                    end
                end
                S_JUMP: begin
                    if (tick_cnt_q == TC_W'(FRAME_TICKS - 1)) begin
                        tick_cnt_q <= '0;
                        if (frame_idx_q < FI_W'(NUM_FRAMES - 1)) begin
                            frame_idx_q <= frame_idx_q + FI_W'(1);
                        end else begin
                            state_q <= S_LAND;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TC_W'(1);
                    end
                end
                S_LAND: begin
                    if (tick_cnt_q == TC_W'(LAND_TICKS - 1)) begin
                        state_q     <= S_IDLE;
                        frame_idx_q <= '0;
                        tick_cnt_q  <= '0;
                        busy_q      <= 1'b0;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TC_W'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    frame_idx_q <= '0;
                    tick_cnt_q  <= '0;
                    busy_q      <= 1'b0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign frame_idx = frame_idx_q;
    assign busy      = busy_q;

    sprite_addr_gen #(
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .NUM_FRAMES (NUM_FRAMES),
        .ADDR_W     (ADDR_W),
        .FI_W       (FI_W)
    ) u_addr_gen (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .facing_left (facing_left),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .frame_idx   (frame_idx_q),
        .rom_address (rom_address),
        .sprite_on   (sprite_on)
    );

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed self-checking bench for sprite_anim_ctrl with default parameters.
module tb_sprite_anim_ctrl;

    logic        vga_clk;
    logic        reset_n;
    logic        frame_tick;
    logic        jump_req;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        facing_left;
    logic [13:0] rom_address;
    logic        sprite_on;
    logic [1:0]  frame_idx;
    logic        busy;

    int err_cnt;
    int chk_cnt;

    sprite_anim_ctrl dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .jump_req    (jump_req),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .facing_left (facing_left),
        .rom_address (rom_address),
        .sprite_on   (sprite_on),
        .frame_idx   (frame_idx),
        .busy        (busy)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-derived frame index after the t-th frame_tick with jump_req held.
    function automatic int exp_frame(input int t);
        if (t == 0)       return 0;
        else if (t <= 6)  return 1;
        else if (t <= 12) return 2;
        else if (t <= 26) return 3;
        else if (t == 27) return 0;
        else              return 1;
    endfunction

    task automatic one_tick();
        @(negedge vga_clk);
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        int mirror_exp;
        err_cnt     = 0;
        chk_cnt     = 0;
        reset_n     = 1'b0;
        frame_tick  = 1'b0;
        jump_req    = 1'b0;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        pos_x       = 10'd0;
        pos_y       = 10'd0;
        facing_left = 1'b0;
`ifdef SPRITE_MIRROR_EN
        mirror_exp = 63;
`else
        mirror_exp = 0;
`endif

        repeat (3) @(negedge vga_clk);
        check_eq("rst_addr", 32'(rom_address), 32'd0);
        check_eq("rst_on", 32'(sprite_on), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_fidx", 32'(frame_idx), 32'd0);
        reset_n = 1'b1;

        @(posedge vga_clk); #1;
        check_eq("origin_addr", 32'(rom_address), 32'd0);
        check_eq("origin_on", 32'(sprite_on), 32'd1);
        check_eq("origin_busy", 32'(busy), 32'd0);
        check_eq("origin_fidx", 32'(frame_idx), 32'd0);

        // Mirroring is latched on a frame_tick
        @(negedge vga_clk);
        facing_left = 1'b1;
        frame_tick  = 1'b1;
        @(negedge vga_clk);
        frame_tick  = 1'b0;
        @(posedge vga_clk); #1;
        check_eq("mirror_addr", 32'(rom_address), 32'(mirror_exp));
        @(negedge vga_clk);
        facing_left = 1'b0;
        one_tick();

        @(negedge vga_clk);
        pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd163; DrawY = 10'd113;
        @(posedge vga_clk); #1;
        check_eq("corner_on", 32'(sprite_on), 32'd1);
        check_eq("corner_addr", 32'(rom_address), 32'd4095);
        @(negedge vga_clk);
        DrawX = 10'd164;
        @(posedge vga_clk); #1;
        check_eq("right_on", 32'(sprite_on), 32'd0);
        check_eq("right_addr", 32'(rom_address), 32'd0);
        @(negedge vga_clk);
        DrawX = 10'd100; DrawY = 10'd49;
        @(posedge vga_clk); #1;
        check_eq("above_on", 32'(sprite_on), 32'd0);

        @(negedge vga_clk);
        pos_x = 10'd600; pos_y = 10'd0; DrawX = 10'd5; DrawY = 10'd0;
        @(posedge vga_clk); #1;
        check_eq("wrap_on", 32'(sprite_on), 32'd0);
        check_eq("wrap_addr", 32'(rom_address), 32'd0);
        @(negedge vga_clk);
        DrawX = 10'd639;
        @(posedge vga_clk); #1;
        check_eq("clip_on", 32'(sprite_on), 32'd1);
        check_eq("clip_addr", 32'(rom_address), 32'd39);

        // Jump with request held; every third tick is followed by a gap, others are back-to-back
        @(negedge vga_clk);
        pos_x = 10'd0; pos_y = 10'd0; DrawX = 10'd1; DrawY = 10'd2;
        jump_req = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge vga_clk);
            frame_tick = 1'b1;
            @(posedge vga_clk); #1;
            check_eq($sformatf("jump_fidx_t%0d", t), 32'(frame_idx), 32'(exp_frame(t)));
            check_eq($sformatf("jump_busy_t%0d", t), 32'(busy), (t == 27) ? 32'd0 : 32'd1);
            check_eq($sformatf("jump_addr_t%0d", t), 32'(rom_address),
                     32'(exp_frame(t - 1) * 4096 + 129));
            if (t % 3 == 0) begin
                @(negedge vga_clk);
                frame_tick = 1'b0;
            end
        end
        @(negedge vga_clk);
        frame_tick = 1'b0;
        jump_req   = 1'b0;

        // Second jump is at frame 1, tick count 2; four more ticks reach frame 2
        repeat (4) one_tick();
        check_eq("pre_rst_fidx", 32'(frame_idx), 32'd2);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);

        @(posedge vga_clk); #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_fidx", 32'(frame_idx), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_on", 32'(sprite_on), 32'd0);
        check_eq("async_addr", 32'(rom_address), 32'd0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        one_tick();
        check_eq("post_rst_fidx", 32'(frame_idx), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
